// File: rtl/hex_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hex_timer_pkg
// Brief   : Timer state type, BCD digit limits, display constants and helpers.
// Rev     : 1.0
// ============================================================================
package hex_timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] c_TENS_MAX     = 4'd5;
   localparam logic [3:0] c_UNITS_MAX    = 4'd9;
   localparam logic [3:0] c_HR_TENS_MAX  = 4'd2;
   localparam logic [3:0] c_HR_UNITS_MAX = 4'd3;  // hours units limit once tens = 2
   localparam logic [7:0] c_BLANK        = 8'hFF;
   localparam logic [7:0] c_DP_MASK      = 8'h7F;

   function automatic logic bcd_valid(input logic [23:0] t);
      return (t[3:0]   <= c_UNITS_MAX) && (t[7:4]   <= c_TENS_MAX) &&
             (t[11:8]  <= c_UNITS_MAX) && (t[15:12] <= c_TENS_MAX) &&
             (t[19:16] <= c_UNITS_MAX) &&
             ((t[23:20] < c_HR_TENS_MAX) ||
              ((t[23:20] == c_HR_TENS_MAX) && (t[19:16] <= c_HR_UNITS_MAX)));
   endfunction

   // One-second step of HH:MM:SS with full ripple carry/borrow and day wrap.
   function automatic logic [23:0] bcd_step(input logic [23:0] t, input logic down);
      logic [3:0] d [6];
      logic       c;
      logic [3:0] lim;
      for (int i = 0; i < 6; i++) d[i] = t[4*i +: 4];
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         lim = (i % 2 == 0) ? c_UNITS_MAX : c_TENS_MAX;
         if (c) begin
            if (down) begin
               if (d[i] == 4'd0) d[i] = lim;
               else begin
                  d[i] = d[i] - 4'd1;
                  c    = 1'b0;
               end
            end else begin
               if (d[i] == lim) d[i] = 4'd0;
               else begin
                  d[i] = d[i] + 4'd1;
                  c    = 1'b0;
               end
            end
         end
      end
      if (c) begin
         if (down) begin
            if ((d[5] == 4'd0) && (d[4] == 4'd0)) begin
               d[5] = c_HR_TENS_MAX;
               d[4] = c_HR_UNITS_MAX;
            end else if (d[4] == 4'd0) begin
               d[4] = c_UNITS_MAX;
               d[5] = d[5] - 4'd1;
            end else begin
               d[4] = d[4] - 4'd1;
            end
         end else begin
            if ((d[5] == c_HR_TENS_MAX) && (d[4] == c_HR_UNITS_MAX)) begin
               d[5] = 4'd0;
               d[4] = 4'd0;
            end else if (d[4] == c_UNITS_MAX) begin
               d[4] = 4'd0;
               d[5] = d[5] + 4'd1;
            end else begin
               d[4] = d[4] + 4'd1;
            end
         end
      end
      return {d[5], d[4], d[3], d[2], d[1], d[0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_encode
// Brief   : BCD digit to active-low gfedcba segments; non-BCD codes blank.
// Rev     : 1.0
// ============================================================================
module seg7_encode (
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = 7'h7F;
      case (i_bcd)
         4'd0:    o_seg = 7'h40;
         4'd1:    o_seg = 7'h79;
         4'd2:    o_seg = 7'h24;
         4'd3:    o_seg = 7'h30;
         4'd4:    o_seg = 7'h19;
         4'd5:    o_seg = 7'h12;
         4'd6:    o_seg = 7'h02;
         4'd7:    o_seg = 7'h78;
         4'd8:    o_seg = 7'h00;
         4'd9:    o_seg = 7'h10;
         default: o_seg = 7'h7F;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/hex_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hex_timer_ctrl
// Brief   : HH:MM:SS up/down timer on six 7-segment digits; define
//           HEX_TIMER_BLINK_EN to blink the display while in DONE.
// Rev     : 1.0
// ============================================================================
module hex_timer_ctrl
   import hex_timer_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int BLINK_HZ = 2
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        load,
   input  logic [23:0] load_bcd,
   input  logic        count_down,
   output logic [7:0]  HEX0,
   output logic [7:0]  HEX1,
   output logic [7:0]  HEX2,
   output logic [7:0]  HEX3,
   output logic [7:0]  HEX4,
   output logic [7:0]  HEX5,
   output logic        running,
   output logic        done
);

   localparam int                   c_PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CLK_HZ - 1);

   if ((CLK_HZ < 2) || (BLINK_HZ < 1) || (CLK_HZ < 2 * BLINK_HZ)) begin : g_param_check
      $error("hex_timer_ctrl: need CLK_HZ >= 2 and CLK_HZ >= 2*BLINK_HZ");
   end

   state_t               r_state, w_state_n;
   logic [23:0]          r_time, w_time_n, w_time_step;
   logic [c_PRESC_W-1:0] r_presc, w_presc_n;
   logic                 r_running, r_done;
   logic                 w_do_load, w_do_stop, w_do_start, w_tick, w_blank;
   logic [6:0]           w_seg [6];
   logic [7:0]           r_hex [6];

   // Only the highest-priority pulse of clear > load > stop > start acts.
   assign w_do_load   = load & ~clear;
   assign w_do_stop   = stop & ~clear & ~load;
   assign w_do_start  = start & ~clear & ~load & ~stop;
   assign w_tick      = (r_state == RUN) && (r_presc == c_PRESC_MAX);
   assign w_time_step = bcd_step(r_time, count_down);

   always_comb begin
      w_state_n = r_state;
      w_time_n  = r_time;
      w_presc_n = r_presc;
      case (r_state)
         IDLE: begin
            if (w_do_start) begin
               w_presc_n = '0;
               w_state_n = (count_down && (r_time == 24'h000000)) ? DONE : RUN;
            end
         end
         RUN: begin
            if (w_do_stop) begin
               w_state_n = PAUSE;
            end else if (w_tick) begin
               w_presc_n = '0;
               if (count_down && (r_time <= 24'h000001)) begin
                  w_time_n  = 24'h000000;
                  w_state_n = DONE;
               end else begin
                  w_time_n = w_time_step;
               end
            end else begin
               w_presc_n = r_presc + 1'b1;
            end
         end
         PAUSE: begin
            if (w_do_start) w_state_n = RUN;
         end
         default: ;
      endcase
      if (w_do_load && ((r_state == IDLE) || (r_state == PAUSE)) && bcd_valid(load_bcd)) begin
         w_time_n  = load_bcd;
         w_presc_n = '0;
      end
      if (clear) begin
         w_state_n = IDLE;
         w_time_n  = 24'h000000;
         w_presc_n = '0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state   <= IDLE;
         r_time    <= 24'h000000;
         r_presc   <= '0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_time    <= w_time_n;
         r_presc   <= w_presc_n;
         r_running <= (w_state_n == RUN);
         r_done    <= (w_state_n == DONE);
      end
   end

`ifdef HEX_TIMER_BLINK_EN
   localparam int                   c_HALF      = CLK_HZ / (2 * BLINK_HZ);
   localparam int                   c_BLINK_W   = (c_HALF > 1) ? $clog2(c_HALF) : 1;
   localparam logic [c_BLINK_W-1:0] c_BLINK_MAX = c_BLINK_W'(c_HALF - 1);

   logic [c_BLINK_W-1:0] r_blink_cnt;
   logic                 r_blink_phase;

   // Held clear outside DONE so every DONE entry starts with the display on.
   always_ff @(posedge CLOCK_50) begin
      if (reset || (r_state != DONE)) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == c_BLINK_MAX) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt   <= r_blink_cnt + 1'b1;
      end
   end

   assign w_blank = (r_state == DONE) && r_blink_phase;
`else
   assign w_blank = 1'b0;
`endif

   for (genvar i = 0; i < 6; i++) begin : g_digit
      seg7_encode u_seg (
         .i_bcd (r_time[4*i +: 4]),
         .o_seg (w_seg[i])
      );
   end

   // HEX2 and HEX4 carry the lit decimal point used as the field separator.
   always_ff @(posedge CLOCK_50) begin
      for (int i = 0; i < 6; i++) begin
         if (reset) begin
            r_hex[i] <= ((i == 2) || (i == 4)) ? (8'hC0 & c_DP_MASK) : 8'hC0;
         end else if (w_blank) begin
            r_hex[i] <= c_BLANK;
         end else begin
            r_hex[i] <= ((i == 2) || (i == 4)) ? ({1'b1, w_seg[i]} & c_DP_MASK)
                                               : {1'b1, w_seg[i]};
         end
      end
   end

   assign HEX0    = r_hex[0];
   assign HEX1    = r_hex[1];
   assign HEX2    = r_hex[2];
   assign HEX3    = r_hex[3];
   assign HEX4    = r_hex[4];
   assign HEX5    = r_hex[5];
   assign running = r_running;
   assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hex_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hex_timer_ctrl
// Brief   : Directed self-checking bench for hex_timer_ctrl (CLK_HZ=10, BLINK_HZ=1).
// Rev     : 1.0
// ============================================================================
module tb_hex_timer_ctrl;

`ifdef HEX_TIMER_BLINK_EN
   localparam bit c_BLINK_ON = 1'b1;
`else
   localparam bit c_BLINK_ON = 1'b0;
`endif
   localparam logic [47:0] c_ZERO_DISP = 48'hC040_C040_C0C0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clear = 1'b0;
   logic        load = 1'b0;
   logic [23:0] load_bcd = 24'h000000;
   logic        count_down = 1'b0;
   logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
   logic        running, done;
   logic [47:0] hex_all;
   logic [47:0] exp_v;
   int          n_checks = 0;
   int          n_fail = 0;

   assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

   always #5 clk = ~clk;

   hex_timer_ctrl #(.CLK_HZ(10), .BLINK_HZ(1)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .clear      (clear),
      .load       (load),
      .load_bcd   (load_bcd),
      .count_down (count_down),
      .HEX0       (hex0),
      .HEX1       (hex1),
      .HEX2       (hex2),
      .HEX3       (hex3),
      .HEX4       (hex4),
      .HEX5       (hex5),
      .running    (running),
      .done       (done)
   );

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 8'hC0;
         4'd1: return 8'hF9;
         4'd2: return 8'hA4;
         4'd3: return 8'hB0;
         4'd4: return 8'h99;
         4'd5: return 8'h92;
         4'd6: return 8'h82;
         4'd7: return 8'hF8;
         4'd8: return 8'h80;
         4'd9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [47:0] exp_display(input logic [23:0] t);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[8*i +: 8] = seg_of(t[4*i +: 4]);
         if ((i == 2) || (i == 4)) r[8*i + 7] = 1'b0;
      end
      return r;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_load(input logic [23:0] v);
      load_bcd = v;
      load = 1'b1;
      cyc(1);
      load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(2);
      n_checks++;
      if (hex_all !== 48'hC040_C040_C0C0) begin
         n_fail++; $display("FAIL reset_hex: got %h expected %h", hex_all, 48'hC040_C040_C0C0);
      end
      n_checks++;
      if (running !== 1'b0) begin
         n_fail++; $display("FAIL reset_running: got %b expected 0", running);
      end
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL reset_done: got %b expected 0", done);
      end
      reset = 1'b0;
      cyc(1);
   endtask

   task automatic test_up_wrap();
      count_down = 1'b0;
      pulse_load(24'h235958);
      pulse_start();
      n_checks++;
      if (hex_all !== exp_display(24'h235958)) begin
         n_fail++; $display("FAIL up_loaded: got %h expected %h", hex_all, exp_display(24'h235958));
      end
      n_checks++;
      if (running !== 1'b1) begin
         n_fail++; $display("FAIL up_running: got %b expected 1", running);
      end
      cyc(10);
      n_checks++;
      if (hex_all !== exp_display(24'h235958)) begin
         n_fail++; $display("FAIL up_hex_lag: got %h expected %h", hex_all, exp_display(24'h235958));
      end
      cyc(1);
      n_checks++;
      if (hex_all !== exp_display(24'h235959)) begin
         n_fail++; $display("FAIL up_235959: got %h expected %h", hex_all, exp_display(24'h235959));
      end
      cyc(10);
      n_checks++;
      if (hex_all !== c_ZERO_DISP) begin
         n_fail++; $display("FAIL up_wrap: got %h expected %h", hex_all, c_ZERO_DISP);
      end
      n_checks++;
      if (running !== 1'b1) begin
         n_fail++; $display("FAIL up_wrap_running: got %b expected 1", running);
      end
      pulse_clear();
   endtask

   task automatic test_start_zero();
      count_down = 1'b1;
      pulse_start();
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL zero_start_done: got %b expected 1", done);
      end
      n_checks++;
      if (running !== 1'b0) begin
         n_fail++; $display("FAIL zero_start_running: got %b expected 0", running);
      end
      pulse_clear();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL clear_from_done: got %b expected 0", done);
      end
   endtask

   task automatic test_down_end();
      count_down = 1'b1;
      pulse_load(24'h000002);
      pulse_start();
      cyc(19);
      n_checks++;
      if ((running !== 1'b1) || (done !== 1'b0)) begin
         n_fail++; $display("FAIL down_pre_end: got running=%b done=%b expected 1/0", running, done);
      end
      n_checks++;
      if (hex_all !== exp_display(24'h000001)) begin
         n_fail++; $display("FAIL down_000001: got %h expected %h", hex_all, exp_display(24'h000001));
      end
      cyc(1);
      n_checks++;
      if ((done !== 1'b1) || (running !== 1'b0)) begin
         n_fail++; $display("FAIL down_done: got running=%b done=%b expected 0/1", running, done);
      end
      cyc(1);
      n_checks++;
      if (hex_all !== c_ZERO_DISP) begin
         n_fail++; $display("FAIL down_hex_zero: got %h expected %h", hex_all, c_ZERO_DISP);
      end
      pulse_start();
      n_checks++;
      if ((done !== 1'b1) || (running !== 1'b0)) begin
         n_fail++; $display("FAIL done_start_ignored: got running=%b done=%b expected 0/1", running, done);
      end
      // DONE entered two edges ago: on for 5 edges, then blank for 5.
      exp_v = c_BLINK_ON ? 48'hFFFF_FFFF_FFFF : c_ZERO_DISP;
      cyc(3);
      n_checks++;
      if (hex_all !== c_ZERO_DISP) begin
         n_fail++; $display("FAIL blink_on_phase: got %h expected %h", hex_all, c_ZERO_DISP);
      end
      cyc(1);
      n_checks++;
      if (hex_all !== exp_v) begin
         n_fail++; $display("FAIL blink_off_start: got %h expected %h", hex_all, exp_v);
      end
      cyc(4);
      n_checks++;
      if (hex_all !== exp_v) begin
         n_fail++; $display("FAIL blink_off_end: got %h expected %h", hex_all, exp_v);
      end
      cyc(1);
      n_checks++;
      if (hex_all !== c_ZERO_DISP) begin
         n_fail++; $display("FAIL blink_on_again: got %h expected %h", hex_all, c_ZERO_DISP);
      end
      pulse_clear();
   endtask

   task automatic test_pause_phase();
      count_down = 1'b0;
      pulse_start();
      cyc(6);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      n_checks++;
      if (running !== 1'b0) begin
         n_fail++; $display("FAIL pause_running: got %b expected 0", running);
      end
      cyc(50);
      n_checks++;
      if (hex_all !== c_ZERO_DISP) begin
         n_fail++; $display("FAIL pause_hold: got %h expected %h", hex_all, c_ZERO_DISP);
      end
      pulse_start();
      cyc(4);
      n_checks++;
      if (hex_all !== c_ZERO_DISP) begin
         n_fail++; $display("FAIL resume_early: got %h expected %h", hex_all, c_ZERO_DISP);
      end
      cyc(1);
      n_checks++;
      if (hex_all !== exp_display(24'h000001)) begin
         n_fail++; $display("FAIL resume_tick: got %h expected %h", hex_all, exp_display(24'h000001));
      end
      pulse_clear();
   endtask

   task automatic test_priority();
      pulse_load(24'h123456);
      cyc(1);
      n_checks++;
      if (hex_all !== exp_display(24'h123456)) begin
         n_fail++; $display("FAIL idle_load: got %h expected %h", hex_all, exp_display(24'h123456));
      end
      clear = 1'b1; load = 1'b1; start = 1'b1; load_bcd = 24'h111111;
      cyc(1);
      clear = 1'b0; load = 1'b0; start = 1'b0;
      cyc(1);
      n_checks++;
      if (hex_all !== c_ZERO_DISP) begin
         n_fail++; $display("FAIL clear_wins_hex: got %h expected %h", hex_all, c_ZERO_DISP);
      end
      n_checks++;
      if ((running !== 1'b0) || (done !== 1'b0)) begin
         n_fail++; $display("FAIL clear_wins_state: got running=%b done=%b expected 0/0", running, done);
      end
      load = 1'b1; start = 1'b1; load_bcd = 24'h102030;
      cyc(1);
      load = 1'b0; start = 1'b0;
      n_checks++;
      if (running !== 1'b0) begin
         n_fail++; $display("FAIL load_beats_start: got running=%b expected 0", running);
      end
      cyc(1);
      n_checks++;
      if (hex_all !== exp_display(24'h102030)) begin
         n_fail++; $display("FAIL load_with_start: got %h expected %h", hex_all, exp_display(24'h102030));
      end
      pulse_load(24'h006000);
      cyc(1);
      n_checks++;
      if (hex_all !== exp_display(24'h102030)) begin
         n_fail++; $display("FAIL bad_minutes_load: got %h expected %h", hex_all, exp_display(24'h102030));
      end
      pulse_load(24'h240000);
      cyc(1);
      n_checks++;
      if (hex_all !== exp_display(24'h102030)) begin
         n_fail++; $display("FAIL bad_hours_load: got %h expected %h", hex_all, exp_display(24'h102030));
      end
      count_down = 1'b0;
      pulse_start();
      pulse_load(24'h000500);
      cyc(1);
      n_checks++;
      if (hex_all !== exp_display(24'h102030)) begin
         n_fail++; $display("FAIL run_load_ignored: got %h expected %h", hex_all, exp_display(24'h102030));
      end
      pulse_clear();
   endtask

   task automatic test_reset_mid_run();
      count_down = 1'b0;
      pulse_load(24'h123456);
      pulse_start();
      cyc(3);
      n_checks++;
      if ((hex_all !== exp_display(24'h123456)) || (running !== 1'b1)) begin
         n_fail++; $display("FAIL pre_reset_run: got hex=%h running=%b expected %h/1", hex_all, running, exp_display(24'h123456));
      end
      reset = 1'b1; start = 1'b1;
      cyc(1);
      n_checks++;
      if (hex_all !== 48'hC040_C040_C0C0) begin
         n_fail++; $display("FAIL mid_reset_hex: got %h expected %h", hex_all, 48'hC040_C040_C0C0);
      end
      n_checks++;
      if ((running !== 1'b0) || (done !== 1'b0)) begin
         n_fail++; $display("FAIL mid_reset_flags: got running=%b done=%b expected 0/0", running, done);
      end
      reset = 1'b0; start = 1'b0;
      cyc(12);
      n_checks++;
      if ((hex_all !== c_ZERO_DISP) || (running !== 1'b0)) begin
         n_fail++; $display("FAIL post_reset_idle: got hex=%h running=%b expected %h/0", hex_all, running, c_ZERO_DISP);
      end
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_start_zero();
      test_down_end();
      test_pause_phase();
      test_priority();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
